// File: rtl/gpio_ctrl.sv
// gpio_ctrl: 4-bit LED register and four debounced push-buttons with sticky press events.
// Accessed over a single-cycle valid/ready bus.
`timescale 1ns/1ps
module gpio_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_ni,
   input  logic       valid,
   input  logic       we,
   input  logic       sel_led,
   input  logic       sel_but,
   input  logic [3:0] data_m,
   output logic [3:0] data_s,
   output logic       ready,
   input  logic [3:0] button,
   output logic [3:0] led,
   output logic       irq
);

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [3:0]      sync1_q, sync2_q;
   logic [3:0]      deb_q, deb_d;
   logic [3:0][7:0] cnt_q, cnt_d;
   logic [3:0]      rise;
   logic [3:0]      events_q, events_d;
   logic [3:0]      led_q, led_d;
   logic [3:0]      data_s_q, data_s_d;
   logic            ready_q;
   logic            irq_q;

   logic wr_led, wr_clr, rd_led, rd_but, rd_evt;

   // Handshake: valid is a one-cycle strobe sampled on a rising edge; ready is
   // high for exactly the next cycle, when the write or read data has landed.
   // There is no backpressure, so every valid cycle is serviced.
   assign wr_led = valid &  we &  sel_led & ~sel_but;
   assign wr_clr = valid &  we &  sel_led &  sel_but;
   assign rd_led = valid & ~we &  sel_led & ~sel_but;
   assign rd_but = valid & ~we & ~sel_led &  sel_but;
   assign rd_evt = valid & ~we &  sel_led &  sel_but;

   // A bit is accepted once it has differed from the debounced value for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      rise  = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
            rise[i]  = sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   // Set is applied after the clear so a press in the clearing cycle survives.
   always_comb begin
      events_d = events_q;
      if (wr_clr) begin
         events_d = events_q & ~data_m;
      end
      events_d = events_d | rise;
   end

   always_comb begin
      led_d = led_q;
      if (wr_led) begin
         led_d = data_m;
      end
   end

   // Reads see registered state, so an event read returns the pre-set value.
   always_comb begin
      data_s_d = data_s_q;
      if (rd_led) begin
         data_s_d = led_q;
      end else if (rd_but) begin
         data_s_d = deb_q;
      end else if (rd_evt) begin
         data_s_d = events_q;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         cnt_q    <= '0;
         events_q <= '0;
         led_q    <= '0;
         data_s_q <= '0;
         ready_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         sync1_q  <= button;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         events_q <= events_d;
         led_q    <= led_d;
         data_s_q <= data_s_d;
         ready_q  <= valid;
         irq_q    <= |events_q;
      end
   end

   assign data_s = data_s_q;
   assign ready  = ready_q;
   assign led    = led_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: read data is predicted when a read is issued
// and compared against what the DUT returns on its ready pulse.
`timescale 1ns/1ps
module tb_gpio_ctrl;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       valid = 1'b0;
   logic       we = 1'b0;
   logic       sel_led = 1'b0;
   logic       sel_but = 1'b0;
   logic [3:0] data_m = 4'h0;
   logic [3:0] button = 4'h0;
   logic [3:0] data_s;
   logic [3:0] led;
   logic       ready;
   logic       irq;

   int tests_run = 0;
   int tests_failed = 0;
   int ready_cnt = 0;

   logic [3:0] exp_q[$];
   logic [3:0] got_q[$];
   bit         kind_q[$];

   gpio_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .rst_ni  (rst_ni),
      .valid   (valid),
      .we      (we),
      .sel_led (sel_led),
      .sel_but (sel_but),
      .data_m  (data_m),
      .data_s  (data_s),
      .ready   (ready),
      .button  (button),
      .led     (led),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Each ready pulse retires the oldest access; reads deliver data_s.
   always @(negedge clk) begin
      if (ready) begin
         ready_cnt++;
         if (kind_q.size() > 0) begin
            if (kind_q.pop_front()) got_q.push_back(data_s);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_op(input logic w, input logic sl, input logic sb, input logic [3:0] d);
      @(negedge clk);
      valid = 1'b1; we = w; sel_led = sl; sel_but = sb; data_m = d;
      kind_q.push_back(!w && (sl || sb));
      @(posedge clk); #1;
      valid = 1'b0; we = 1'b0; sel_led = 1'b0; sel_but = 1'b0; data_m = 4'h0;
   endtask

   task automatic rd_op(input logic sl, input logic sb, input logic [3:0] e);
      exp_q.push_back(e);
      bus_op(1'b0, sl, sb, 4'h0);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      #12;
      tests_run++;
      if ({led, data_s, ready, irq} !== 10'h0) begin
         tests_failed++;
         $display("FAIL reset_state: led=%h data_s=%h ready=%b irq=%b, expected all 0", led, data_s, ready, irq);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      valid = 1'b1; we = 1'b1; sel_led = 1'b1; sel_but = 1'b0; data_m = 4'h5;
      kind_q.push_back(1'b0);
      @(posedge clk); #1;
      valid = 1'b0; we = 1'b0; sel_led = 1'b0; data_m = 4'h0;
      tests_run++;
      if (led !== 4'h5 || ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_access: led=%h ready=%b, expected led=5 ready=1", led, ready);
      end
   endtask

   task automatic test_led;
      int r0;
      logic [3:0] e, g;
      idle(2); #1;
      r0 = ready_cnt;
      bus_op(1'b1, 1'b1, 1'b0, 4'hA);
      tests_run++;
      if (led !== 4'hA) begin
         tests_failed++;
         $display("FAIL led_write: led=%h expected a", led);
      end
      idle(2); #1;
      tests_run++;
      if (ready_cnt - r0 != 1) begin
         tests_failed++;
         $display("FAIL led_ready_pulse: %0d ready cycles, expected 1", ready_cnt - r0);
      end
      rd_op(1'b1, 1'b0, 4'hA);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL led_readback: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_noop;
      int r0;
      logic [3:0] e, g;
      r0 = ready_cnt;
      bus_op(1'b1, 1'b0, 1'b1, 4'h3);
      bus_op(1'b1, 1'b0, 1'b0, 4'h6);
      bus_op(1'b0, 1'b0, 1'b0, 4'h0);
      idle(2); #1;
      tests_run++;
      if (led !== 4'hA || data_s !== 4'hA) begin
         tests_failed++;
         $display("FAIL noop_state: led=%h data_s=%h, expected led=a data_s=a", led, data_s);
      end
      tests_run++;
      if (ready_cnt - r0 != 3) begin
         tests_failed++;
         $display("FAIL noop_ready: %0d ready cycles, expected 3", ready_cnt - r0);
      end
      rd_op(1'b1, 1'b1, 4'h0);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL noop_events: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_debounce;
      logic [3:0] e, g;
      @(negedge clk);
      button[0] = 1'b1;
      // Read i is sampled on edge i+1 after the change; debounced value moves on edge 6.
      for (int i = 1; i <= 8; i++) rd_op(1'b0, 1'b1, (i >= 6) ? 4'h1 : 4'h0);
      @(negedge clk);
      button[1] = 1'b1;
      repeat (3) @(negedge clk);
      button[1] = 1'b0;
      for (int i = 0; i < 10; i++) rd_op(1'b0, 1'b1, 4'h1);
      @(negedge clk);
      button[0] = 1'b0;
      idle(8);
      rd_op(1'b0, 1'b1, 4'h0);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL debounce: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_events;
      logic [3:0] e, g;
      bus_op(1'b1, 1'b1, 1'b1, 4'hF);
      idle(2); #1;
      tests_run++;
      if (irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL irq_idle: irq=%b expected 0", irq);
      end
      @(negedge clk);
      button[2] = 1'b1;
      idle(4);
      rd_op(1'b1, 1'b1, 4'h0);
      rd_op(1'b1, 1'b1, 4'h4);
      tests_run++;
      if (irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_set: irq=%b expected 1", irq);
      end
      @(negedge clk);
      button[2] = 1'b0;
      idle(8);
      rd_op(1'b1, 1'b1, 4'h4);
      tests_run++;
      if (irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_after_release: irq=%b expected 1", irq);
      end
      bus_op(1'b1, 1'b1, 1'b1, 4'h4);
      rd_op(1'b1, 1'b1, 4'h0);
      tests_run++;
      if (irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL irq_clear: irq=%b expected 0", irq);
      end
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL events: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_set_wins;
      logic [3:0] e, g;
      bus_op(1'b1, 1'b1, 1'b1, 4'hF);
      @(negedge clk);
      button[3] = 1'b1;
      idle(4);
      // This clear is sampled on the same edge that bit 3 is accepted.
      bus_op(1'b1, 1'b1, 1'b1, 4'h8);
      rd_op(1'b1, 1'b1, 4'h8);
      @(negedge clk);
      button[3] = 1'b0;
      idle(8);
      rd_op(1'b1, 1'b1, 4'h8);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL set_wins: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_reset_mid;
      logic [3:0] e, g;
      bus_op(1'b1, 1'b1, 1'b0, 4'hF);
      @(negedge clk);
      button[1] = 1'b1;
      idle(2);
      rd_op(1'b1, 1'b0, 4'hF);
      @(negedge clk); #2;
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if ({led, data_s, ready, irq} !== 10'h0) begin
         tests_failed++;
         $display("FAIL async_reset: led=%h data_s=%h ready=%b irq=%b, expected all 0", led, data_s, ready, irq);
      end
      idle(2);
      @(negedge clk);
      rst_ni = 1'b1;
      for (int i = 1; i <= 8; i++) rd_op(1'b0, 1'b1, (i >= 6) ? 4'h2 : 4'h0);
      rd_op(1'b1, 1'b1, 4'h2);
      rd_op(1'b1, 1'b0, 4'h0);
      @(negedge clk);
      button[1] = 1'b0;
      idle(8);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL reset_mid: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back;
      int r0;
      logic [3:0] e, g;
      r0 = ready_cnt;
      bus_op(1'b1, 1'b1, 1'b0, 4'h3);
      rd_op(1'b1, 1'b0, 4'h3);
      rd_op(1'b0, 1'b1, 4'h0);
      rd_op(1'b1, 1'b1, 4'h2);
      bus_op(1'b1, 1'b1, 1'b1, 4'hF);
      rd_op(1'b1, 1'b1, 4'h0);
      @(negedge clk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); tests_run++;
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 4'hx;
         if (g !== e) begin tests_failed++; $display("FAIL back_to_back: data_s=%h expected %h", g, e); end
      end
      got_q.delete();
      idle(1); #1;
      tests_run++;
      if (ready_cnt - r0 != 6) begin
         tests_failed++;
         $display("FAIL b2b_ready: %0d ready cycles, expected 6", ready_cnt - r0);
      end
   endtask

   initial begin
      test_reset();
      test_led();
      test_noop();
      test_debounce();
      test_events();
      test_set_wins();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
